// File: rtl/nx_ram_1r1w_rd_stream.sv
// rtl/nx_ram_1r1w_rd_stream.sv - read-side streaming engine for an nx_ram_1r1w instance
//
// Accepts a (base, length) command and reads the attached RAM sequentially through
// its active-low read port, wrapping addresses modulo DEPTH. An in-flight tracker
// and a credit-limited capture buffer absorb the fixed RAM read latency, and the
// words leave on a valid/ready stream with a last marker.
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake, ready only in IDLE
//   cmd_base, cmd_len               first address and word count (0..DEPTH)
//   ram_reb, ram_ra, ram_dout       RAM read port (reb active-low)
//   out_valid/out_ready             output word handshake
//   out_data, out_last              output word and final-word marker
//   done                            one-cycle pulse when a command completes
//   busy                            high in RUN or DRAIN
module nx_ram_1r1w_rd_stream #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1,
  parameter int OUT_FLOP   = 0,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_base,
  input  logic [AW:0]      cmd_len,
  output logic             ram_reb,
  output logic [AW-1:0]    ram_ra,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic             busy
);

  localparam int L         = RD_LATENCY + OUT_FLOP;
  localparam int BUF_DEPTH = L + 2;
  localparam int PW        = $clog2(BUF_DEPTH);
  localparam int CW        = $clog2(BUF_DEPTH + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    addr, ra_q, addr_inc;
  logic [AW:0]      remaining, len_q, tag;
  logic [L-1:0]     trk, trk_nx;
  logic [CW-1:0]    occ, inflight;
  logic [WIDTH-1:0] buf_data [BUF_DEPTH];
  logic             buf_last [BUF_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             accept, issue, push, pop, push_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = (cmd_len == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (issue && remaining == (AW+1)'(1)) state_nx = S_DRAIN;
      S_DRAIN: if (occ == '0 && inflight == '0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs; credit uses registered occ/inflight, so a same-cycle pop frees nothing yet
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    issue     = (state == S_RUN) && (remaining != '0) &&
                ((occ + inflight) < CW'(BUF_DEPTH));
    done      = (state == S_DRAIN) && (occ == '0) && (inflight == '0);
  end

  assign accept   = cmd_valid & cmd_ready;
  assign ram_reb  = ~issue;
  assign ram_ra   = issue ? addr : ra_q;
  assign addr_inc = (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);

  // Tracker bit k is set k+1 cycles after an issue; bit L-1 flags the only cycle
  // in which ram_dout carries that read's data.
  always_comb begin
    trk_nx[0] = issue;
    for (int i = 1; i < L; i++) trk_nx[i] = trk[i-1];
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) inflight = inflight + CW'(trk[i]);
  end

  assign push      = trk[L-1];
  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;
  assign push_last = (tag == len_q - (AW+1)'(1));
  assign out_data  = buf_data[rd_ptr];
  assign out_last  = out_valid & buf_last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      ra_q      <= '0;
      remaining <= '0;
      len_q     <= '0;
      tag       <= '0;
      trk       <= '0;
      occ       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        addr      <= cmd_base;
        remaining <= cmd_len;
        len_q     <= cmd_len;
      end else if (issue) begin
        addr      <= addr_inc;
        remaining <= remaining - (AW+1)'(1);
        ra_q      <= addr;
      end

      trk <= trk_nx;

      if (accept)    tag <= '0;
      else if (push) tag <= tag + (AW+1)'(1);

      if (push) begin
        buf_data[wr_ptr] <= ram_dout;
        buf_last[wr_ptr] <= push_last;
        wr_ptr <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_nx_ram_1r1w_rd_stream.sv
// tb/tb_nx_ram_1r1w_rd_stream.sv - self-checking bench for nx_ram_1r1w_rd_stream
module tb_nx_ram_1r1w_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_ready;
  logic [7:0]  cmd_base;
  logic [8:0]  cmd_len;
  logic [1:0]  ram_reb;
  logic [7:0]  ram_ra [2];
  logic [63:0] ram_dout [2];
  logic [1:0]  out_valid;
  logic        out_ready;
  logic [63:0] out_data [2];
  logic [1:0]  out_last;
  logic [1:0]  done;
  logic [1:0]  busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] word_of(input logic [7:0] a);
    return {24'hC0FFEE, a, 24'h5A5A5A, ~a};
  endfunction

  // Instance 0: L=1 (RD_LATENCY 1, no out flop). Instance 1: L=3 (RD_LATENCY 2, out flop).
  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int RDL = (g == 0) ? 1 : 2;
    localparam int OF  = (g == 0) ? 0 : 1;
    localparam int LL  = RDL + OF;

    nx_ram_1r1w_rd_stream #(
      .WIDTH(64), .DEPTH(256), .RD_LATENCY(RDL), .OUT_FLOP(OF)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_base(cmd_base), .cmd_len(cmd_len),
      .ram_reb(ram_reb[g]), .ram_ra(ram_ra[g]), .ram_dout(ram_dout[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready),
      .out_data(out_data[g]), .out_last(out_last[g]),
      .done(done[g]), .busy(busy[g])
    );

    // RAM read pipe: first stage loads only while reb is low, later stages shift always
    logic [63:0] pipe [LL];
    always @(posedge clk) begin
      if (!ram_reb[g]) pipe[0] <= word_of(ram_ra[g]);
      for (int k = 1; k < LL; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_dout[g] = pipe[LL-1];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and monitor state
  logic [64:0] exp_q [$];
  logic [7:0]  addr_q [$];
  logic [64:0] mon_e;
  int  cur = 0, t0 = 0, rdy_mode = 0;
  bit  mon_en = 0;
  int  issues, pops, first_issue, first_valid, done_cyc, max_out;
  bit  prev_stall;
  logic [63:0] prev_data;
  logic        prev_last;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (rdy_mode == 0);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (!ram_reb[cur]) begin
        if (first_issue < 0) first_issue = cyc - t0;
        issues++;
        if (addr_q.size() == 0) chk("extra_read", 1, 0);
        else chk("read_addr", ram_ra[cur], addr_q.pop_front());
      end
      if (out_valid[cur] && first_valid < 0) first_valid = cyc - t0;
      if (prev_stall) begin
        chk("stall_data", out_data[cur], prev_data);
        chk("stall_last", out_last[cur], prev_last);
      end
      if (out_valid[cur] && out_ready) begin
        pops++;
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("word_data", out_data[cur], mon_e[63:0]);
          chk("word_last", out_last[cur], mon_e[64]);
        end
      end
      prev_stall = out_valid[cur] && !out_ready;
      prev_data  = out_data[cur];
      prev_last  = out_last[cur];
      if (issues - pops > max_out) max_out = issues - pops;
      if (done[cur]) begin
        if (done_cyc < 0) done_cyc = cyc - t0;
        else chk("done_twice", 1, 0);
      end
    end
  end

  task automatic run_cmd(input int sel, input int base, input int len, input int mode,
                         input int exp_first, input int exp_done);
    int t;
    int bufd;
    bufd = (sel == 0) ? 3 : 5;
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < len; i++) begin
      addr_q.push_back(8'((base + i) % 256));
      exp_q.push_back({(i == len - 1), word_of(8'((base + i) % 256))});
    end
    cur = sel; rdy_mode = mode;
    issues = 0; pops = 0; first_issue = -1; first_valid = -1; done_cyc = -1;
    max_out = 0; prev_stall = 0;
    @(posedge clk); #1;
    t0 = cyc; mon_en = 1;
    chk("ready_idle", cmd_ready[sel], 1);
    cmd_valid[sel] = 1'b1;
    cmd_base = 8'(base);
    cmd_len = 9'(len);
    @(posedge clk); #1;
    cmd_valid[sel] = 1'b0;
    chk("busy_run", busy[sel], 1);
    chk("ready_busy", cmd_ready[sel], 0);
    t = 0;
    while (done_cyc < 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    chk("ready_after_done", cmd_ready[sel], 1);
    chk("busy_after_done", busy[sel], 0);
    mon_en = 0;
    chk("first_issue", first_issue, (len > 0) ? 1 : -1);
    chk("first_valid", first_valid, exp_first);
    if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    chk("pop_count", pops, len);
    chk("issue_count", issues, len);
    chk("left_words", exp_q.size(), 0);
    chk("credit_bound", (max_out <= bufd), 1);
  endtask

  typedef struct {
    int sel; int base; int len; int mode; int first; int dn;
  } vec_t;
  vec_t vt [7];

  initial begin
    vt[0] = '{0, 'h10, 4,   0, 3,  7};
    vt[1] = '{0, 254,  4,   0, 3,  7};
    vt[2] = '{0, 5,    0,   0, -1, 1};
    vt[3] = '{0, 'hF0, 1,   0, 3,  4};
    vt[4] = '{1, 0,    256, 0, 5,  261};
    vt[5] = '{1, 'h40, 16,  1, 5,  -1};
    vt[6] = '{1, 255,  3,   0, 5,  8};

    rst_n = 1'b0;
    cmd_valid = 2'b00;
    cmd_base = '0;
    cmd_len = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_cmd_ready", cmd_ready[g], 1);
      chk("rst_ram_reb", ram_reb[g], 1);
      chk("rst_ram_ra", ram_ra[g], 0);
      chk("rst_out_valid", out_valid[g], 0);
      chk("rst_out_last", out_last[g], 0);
      chk("rst_out_data", out_data[g], 0);
      chk("rst_done", done[g], 0);
      chk("rst_busy", busy[g], 0);
    end

    for (int i = 0; i < 7; i++)
      run_cmd(vt[i].sel, vt[i].base, vt[i].len, vt[i].mode, vt[i].first, vt[i].dn);

    // Reset with three reads in flight on the L=3 instance, output stalled
    rdy_mode = 2;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b1;
    cmd_base = 8'h80;
    cmd_len = 9'd16;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_busy", busy[1], 1);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_valid", out_valid[1], 0);
      chk("post_reset_reb", ram_reb[1], 1);
    end
    run_cmd(1, 0, 2, 0, 5, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nx_ram_1r1w_rd_stream.md
# nx_ram_1r1w_rd_stream

Read-side streaming engine for an `nx_ram_1r1w` instance. It accepts a (base, length) command and issues sequential reads on the RAM's active-low read port, with addresses wrapping modulo DEPTH. It absorbs the RAM's fixed read latency with an in-flight tracker and a credit-limited capture buffer. The words are delivered on a valid/ready stream with a last marker. It is the consumer end of the RAM's read interface; the write port belongs to the producer and is not touched.

## Interface
- WIDTH, 64, RAM word width; sets the width of `ram_dout` and `out_data`.
- DEPTH, 256, RAM depth; address width AW = clog2(DEPTH).
- RD_LATENCY, 1, RAM read-register stages; must match the attached RAM.
- OUT_FLOP, 0, 1 when the RAM output flop is enabled; must match the attached RAM.
- Derived constants: L = RD_LATENCY + OUT_FLOP; BUF_DEPTH = L + 2.

Ports:
- clk  in  1  clock; same clock as the attached RAM.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  a command is offered.
- cmd_ready  out  1  the block can accept a command; high only in IDLE.
- cmd_base  in  AW  first read address.
- cmd_len  in  AW+1  number of words to read, 0..DEPTH.
- ram_reb  out  1  RAM read enable, active-low.
- ram_ra  out  AW  RAM read address.
- ram_dout  in  WIDTH  RAM read data.
- out_valid  out  1  output word is valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WIDTH  output word.
- out_last  out  1  qualifies the final word of the command.
- done  out  1  one-cycle pulse when a command completes.
- busy  out  1  high in RUN or DRAIN.

## Operation
- State machine with three states: IDLE, RUN, DRAIN.
- IDLE
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`: load addr = `cmd_base`, remaining = `cmd_len`.
  - If `cmd_len` = 0: go to DRAIN. No reads are issued.
  - Otherwise: go to RUN.
- RUN
  - Issue a read (`ram_reb` = 0, `ram_ra` = addr) when remaining > 0 and occ + inflight < BUF_DEPTH.
  - occ and inflight are registered counts; a same-cycle pop does not return credit in that cycle.
  - On each issue: addr = (addr + 1) mod DEPTH, remaining decrements.
  - When the issue that brings remaining to 0 happens, go to DRAIN.
- DRAIN
  - Wait until inflight = 0 and occ = 0.
  - Then pulse `done` for one cycle and return to IDLE.
- In-flight tracker
  - L-bit shift register. Bit 0 is set in a cycle where `ram_reb` = 0.
  - Bit L−1 marks the cycle in which `ram_dout` holds that read's data. The buffer captures `ram_dout` in exactly that cycle.
  - Reason: the RAM updates its first data stage only while `reb` is low, and later stages shift every cycle, so data is present only in that one cycle.
  - inflight = popcount of the shift register.
- Capture buffer
  - BUF_DEPTH-entry FIFO with registered storage.
  - Pushes can never overflow, because of the credit rule.
  - `out_valid` = (occ ≠ 0).
  - A word pops on `out_valid & out_ready`.
  - Push and pop in the same cycle leave occ unchanged.
- out_last
  - A word-tag counter counts pushes.
  - `out_last` is high with the word whose push index equals the command length − 1.
  - `out_last` never asserts for a length-0 command.
- `ram_reb` = 1 whenever no read is issued; `ram_ra` holds its last value.
- Output stability: while `out_valid & !out_ready`, `out_data` and `out_last` stay stable.

## Timing
- Reset values: state IDLE, `cmd_ready` 1, `ram_reb` 1, `ram_ra` 0, `out_valid` 0, `out_last` 0, `out_data` 0, `done` 0, `busy` 0, occ/inflight/counters 0.
- Handshake at cycle 0:
  - First read is issued in cycle 1.
  - `ram_dout` is valid in cycle 1+L and is captured at the end of that cycle.
  - `out_valid` first rises in cycle L+2.
- Throughput: with `out_ready` held high, one read issues and one word pops every cycle after fill.
- Completion:
  - `done` pulses in the cycle after the final pop.
  - `cmd_ready` rises in the cycle after `done`.
  - For `cmd_len` = 0, `done` pulses in cycle 1 and `cmd_ready` returns to 1 in cycle 2.
- Wrap-around: address DEPTH−1 is followed by address 0.
- `cmd_len` = DEPTH reads every word exactly once.
- Commands arriving outside IDLE are not accepted (`cmd_ready` = 0).
- Reset mid-operation:
  - All state clears asynchronously.
  - In-flight RAM data returning after reset release is ignored, because the tracker is cleared.
  - `out_valid` stays 0 until a new command is accepted.

## Test plan
- Basic read, L=1: preload mem[0x10..0x13] = A,B,C,D; command base 0x10, len 4, `out_ready` = 1.
  - Reads issued in cycles 1–4.
  - Output A,B,C,D in cycles 3–6, with `out_last` on D.
  - `done` in cycle 7.
- Backpressure, RD_LATENCY=2, OUT_FLOP=1 (L=3), len 16: toggle `out_ready` randomly.
  - All 16 words delivered in order with none dropped or duplicated.
  - occ + inflight never exceeds 5.
  - Words held stable while stalled.
- Wrap-around, DEPTH 256: command base 254, len 4.
  - `ram_ra` sequence 254, 255, 0, 1.
  - Data matches those locations.
- Length zero: command len 0.
  - No `ram_reb` low at any point.
  - `done` in cycle 1, `out_valid` never high.
- Reset mid-stream: assert `rst_n` low during RUN with 3 reads in flight, release, then issue command base 0, len 2.
  - Only the 2 new words appear.
  - `out_last` on the second word.
- Full sweep, L=3: command len 256 with `out_ready` = 1.
  - One word per cycle after a fill of 5 cycles.
  - 256 pops in total; `done` in cycle 261.
